// File: rtl/exception_sequencer.sv
// Exception sequencer: takes over the IorD selector on an exception, saves EPC,
// fetches the handler byte from vector 253/254/255, then loads PC.
// Optional EXC_DROP_CNT_EN adds a saturating count of requests ignored while busy.
module exception_sequencer #(
  parameter int unsigned MEM_WAIT  = 2,
  parameter logic [31:0] PC_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  iord_sel_in,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  iord_sel,
  output logic        epc_wr,
  output logic [31:0] epc_data,
  output logic        pc_wr,
  output logic [31:0] pc_data,
  output logic        busy,
  output logic [1:0]  exc_cause
`ifdef EXC_DROP_CNT_EN
  ,
  output logic [7:0]  drop_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SAVE  = 2'd1;
  localparam logic [1:0] FETCH = 2'd2;
  localparam logic [1:0] LOAD  = 2'd3;

  localparam logic [3:0] CNT_LAST = 4'(MEM_WAIT - 1);

  logic [1:0] state, state_nxt;
  logic [1:0] cause_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       any_req;
  logic [1:0] req_cause;
  logic [2:0] vector;
  logic       unused_mem_hi;

  assign any_req = exc_opcode | exc_overflow | exc_div0;

  // Opcode outranks overflow, which outranks div0; losers are dropped.
  always_comb begin
    if (exc_opcode)        req_cause = 2'd1;
    else if (exc_overflow) req_cause = 2'd2;
    else                   req_cause = 2'd3;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cause_nxt = exc_cause;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = SAVE;
          cause_nxt = req_cause;
        end
      end
      SAVE: begin
        state_nxt = FETCH;
        cnt_nxt   = '0;
      end
      FETCH: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == CNT_LAST) state_nxt = LOAD;
      end
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      exc_cause <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      exc_cause <= cause_nxt;
    end
  end

  // Causes 1/2/3 map onto selector codes 3/4/5 (addresses 253/254/255).
  assign vector        = {1'b0, exc_cause} + 3'd2;
  assign busy          = (state != IDLE);
  assign iord_sel      = busy ? vector : iord_sel_in;
  assign epc_wr        = (state == SAVE);
  assign pc_wr         = (state == LOAD);
  assign epc_data      = pc_in - PC_OFFSET;
  assign pc_data       = pc_wr ? {24'b0, mem_data_in[7:0]} : '0;
  assign unused_mem_hi = ^mem_data_in[31:8];

`ifdef EXC_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (busy && any_req && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
Multicycle-CPU controller that arbitrates the memory-address source selector (IorD select) between the main control unit and exception handling. While idle it passes the main control's selector through unchanged. On an exception it seizes the selector and saves EPC. It then drives the vector address 253/254/255 for the cause, waits for memory, and loads PC with the zero-extended handler byte. The block sits between the control unit, the IorD mux, EPC and the PC register.

Parameters:
MEM_WAIT, 2, cycles the vector address is held before memory data is valid (legal range 1..15)
PC_OFFSET, 4, value subtracted from pc_in to form the EPC value

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
iord_sel_in  in  3  selector requested by the main control unit
exc_opcode  in  1  invalid-opcode exception request, level, sampled in IDLE
exc_overflow  in  1  ALU overflow exception request
exc_div0  in  1  divide-by-zero exception request
pc_in  in  32  current PC value, already incremented past the faulting instruction
mem_data_in  in  32  memory read data; only bits [7:0] are used
iord_sel  out  3  selector driven to the IorD mux
epc_wr  out  1  EPC write enable, one-cycle pulse
epc_data  out  32  value to be written to EPC
pc_wr  out  1  PC write enable, one-cycle pulse
pc_data  out  32  value to be written to PC
busy  out  1  high while the sequence runs; the main control must stall
exc_cause  out  2  last accepted cause: 0 none, 1 opcode, 2 overflow, 3 div0

Behaviour:
- States: IDLE, SAVE, FETCH, LOAD. Moore outputs, decoded from registered state plus the registered cause and counter.
- Reset (reset=0, asynchronous): state=IDLE, exc_cause=0, wait counter=0.
  - Outputs during reset: iord_sel=iord_sel_in, epc_wr=0, pc_wr=0, busy=0, epc_data=pc_in-PC_OFFSET (combinational), pc_data=0.
- IDLE:
  - iord_sel=iord_sel_in, busy=0.
  - If any request is high at a rising edge: latch the cause and go to SAVE.
  - Simultaneous requests resolve with priority opcode > overflow > div0. Lower-priority requests are discarded, not queued.
- SAVE (1 cycle): busy=1, epc_wr=1, epc_data=pc_in-PC_OFFSET (32-bit, wraps modulo 2^32), iord_sel=vector. Next state is FETCH with counter=0.
- Vector selection by cause:
  - opcode: 3'b011 (address 253)
  - overflow: 3'b100 (address 254)
  - div0: 3'b101 (address 255)
- FETCH (MEM_WAIT cycles): busy=1, iord_sel=vector. The counter increments each cycle; when counter==MEM_WAIT-1, go to LOAD.
- LOAD (1 cycle): busy=1, iord_sel=vector, pc_wr=1, pc_data={24'b0, mem_data_in[7:0]}. Next state is IDLE.
- pc_data is 0 whenever pc_wr=0. epc_wr and pc_wr are never high in the same cycle.
- Latency: request seen at edge N gives epc_wr high in cycle N+1 and pc_wr high in cycle N+2+MEM_WAIT.
  - busy is high for exactly MEM_WAIT+2 cycles.
  - The first IDLE cycle after LOAD can accept a new request.
- Requests arriving while busy=1 are ignored.
- exc_cause holds its value until the next accepted exception; it is cleared only by reset.
- Reset asserted mid-sequence aborts immediately: any pending pc_wr is lost and the selector returns to passthrough.
- iord_sel_in values 3'b011..3'b101 from the main control are passed through in IDLE without interpretation.

Optional Feature:
EXC_DROP_CNT_EN
- Defined: adds port drop_cnt (out, 8 bits), reset to 0. It increments by 1 on each rising edge where busy=1 and any request is high, and saturates at 255.
- IDLE-cycle simultaneous-request losers are not counted.
- Undefined: the port is absent and there is no counter logic.

Test Plan:
1. Reset released, no requests, iord_sel_in cycles 0..5 -> iord_sel tracks iord_sel_in every cycle; busy=0; epc_wr=pc_wr=0; exc_cause=0.
2. MEM_WAIT=2, exc_overflow pulsed at edge N, pc_in=0x00000108 -> cycle N+1: epc_wr=1 with epc_data=0x00000104. Cycles N+1..N+4: iord_sel=3'b100 and busy=1. Cycle N+4: pc_wr=1 with pc_data=0x000000AB when mem_data_in=0x123456AB. exc_cause=2.
3. exc_opcode, exc_overflow and exc_div0 asserted together -> vector 3'b011; exc_cause=1; one sequence only.
4. exc_div0 with pc_in=0x00000002 -> epc_data=0xFFFFFFFE (wrap); vector 3'b101; exc_cause=3.
5. exc_opcode re-asserted during FETCH -> ignored, and the sequence length is unchanged. With EXC_DROP_CNT_EN, drop_cnt increments once per busy cycle with a request high, and saturates at 255 after 300 such cycles.
6. reset driven low in the FETCH cycle -> iord_sel=iord_sel_in immediately, busy=0, no pc_wr pulse; after release, a new exc_div0 gets a full MEM_WAIT+2 sequence.
